dfa_string_driver: RTL and testbench
====================================

# dfa_string_driver

Upstream feeder for the single-bit DFA recognisers in `fsm/dfa`, such as the ends-with-0 acceptor. It accepts one binary string per valid/ready transfer, given as a data word plus a length. It resets the attached DFA, shifts the string into it one bit per clock, then samples the DFA's `accept` and returns the verdict on a second valid/ready handshake. It turns free-running bit-level recognisers into transaction-level blocks that a testbench or controller can drive.

## Interface
Parameters:
- `WIDTH`, default 8: maximum string length in bits, and the width of `s_data`.
- `LEN_W`, default `$clog2(WIDTH+1)`: width of the length fields.

Ports:
- Clock and reset: one clock; reset is synchronous and active-high.
  - `clk`  in  1  clock; all logic is on the rising edge.
  - `rst`  in  1  synchronous, active-high reset.
- Request side:
  - `s_valid`  in  1  request valid.
  - `s_ready`  out  1  driver can take a request.
  - `s_data`  in  WIDTH  string bits; the string is `s_data[len-1:0]`.
  - `s_len`  in  LEN_W  string length, 0..WIDTH.
- DFA side:
  - `dfa_rst`  out  1  reset to the attached DFA; active-high and glitch-free.
  - `dfa_in`  out  1  bit presented to the DFA.
  - `dfa_accept`  in  1  the DFA's `accept` output.
- Result side:
  - `r_valid`  out  1  verdict valid.
  - `r_ready`  in  1  verdict consumed.
  - `r_accept`  out  1  verdict: 1 means the string was accepted.
  - `r_len`  out  LEN_W  effective length of the string that was run.

## Operation
- FSM is one-hot with states IDLE, SHIFT, SAMPLE, RESULT. All outputs decode directly from state bits or registers, with no combinational path from inputs.
- IDLE:
  - `s_ready`=1 and `dfa_rst`=1, so the DFA is held in its start state.
  - On `s_valid`: latch the data into the shift register and latch the length into the counter and `r_len`.
  - If `s_len` > WIDTH, it is saturated to WIDTH.
  - Next state is SHIFT if the length is nonzero, otherwise SAMPLE (empty string).
- SHIFT:
  - `dfa_rst`=0.
  - `dfa_in` carries the current bit, MSB-first: `s_data[len-1]` first, `s_data[0]` last.
  - One bit per cycle; the counter decrements each cycle.
  - On the cycle the counter reads 1, next state is SAMPLE.
- SAMPLE:
  - `dfa_rst`=0, `dfa_in`=0.
  - The DFA state now reflects all bits; capture `r_accept <= dfa_accept`.
  - Next state is RESULT.
- RESULT:
  - `r_valid`=1; `r_accept` and `r_len` are held stable.
  - On `r_ready`, next state is IDLE.
- `dfa_in`=0 in every state except SHIFT.
- Counter and length arithmetic is unsigned LEN_W. The shift register is WIDTH bits and zero-filled.

## Timing
- Reset values: state=IDLE, `s_ready`=1, `dfa_rst`=1, `dfa_in`=0, `r_valid`=0, `r_accept`=0, `r_len`=0, counter=0.
- `s_ready` is high only in IDLE. There is no skid buffer, so at most one string is in flight.
- Request handshake at edge t, length L ≥ 1:
  - Bits are on `dfa_in` in cycles t+1 .. t+L.
  - SAMPLE occurs in cycle t+L+1.
  - `r_valid` rises in cycle t+L+2.
- L=0: SAMPLE occurs in cycle t+1 and `r_valid` rises in t+2. The verdict is the DFA's start-state accept.
- `r_valid` stays high under `r_ready`=0 indefinitely. Result fields do not change while `r_valid`=1.
- Result handshake at edge u: IDLE in u+1, so the next request can be accepted at edge u+1.
- `rst` mid-operation:
  - Takes effect at the next edge and discards the in-flight string.
  - `r_valid` drops and `dfa_rst` rises in that cycle.
- `s_valid` outside IDLE is ignored, because `s_ready`=0.

## Configuration
- `DFA_DRV_LSB_FIRST_EN` defined: strings are sent LSB-first, `s_data[0]` first and `s_data[len-1]` last. The load places bit 0 at the shift-out position.
- Macro undefined (the default): MSB-first as described in Operation.
- Latency, handshakes and reset behaviour are identical in both builds.

## Test plan
All scenarios run with the ends-with-0 DFA attached.
- `s_data`=8'b0000_0110, `s_len`=3, handshake at t:
  - MSB-first build: `dfa_in`=1,1,0 over t+1..t+3; `r_valid` at t+5 with `r_accept`=1 and `r_len`=3.
  - LSB-first build: sequence is 0,1,1 and `r_accept`=0.
- `s_len`=0: `r_valid` at t+2 with `r_accept`=1 and `r_len`=0; `dfa_in` stays 0 throughout.
- `s_len`=9 with WIDTH=8 and `s_data`=8'hFF: exactly 8 SHIFT cycles, `r_len`=8, `r_accept`=0.
- Hold `r_ready`=0 for 20 cycles: `r_valid`, `r_accept` and `r_len` stay stable and `s_ready`=0. Then `r_ready`=1: `s_ready`=1 the next cycle.
- Assert `rst` for 1 cycle during the 2nd SHIFT cycle of an 8-bit string: the next cycle shows IDLE, `dfa_rst`=1, `r_valid`=0. A fresh request then completes normally.
- 4 back-to-back requests with `r_ready` tied to 1: each `s_ready` rises exactly 1 cycle after the previous result handshake.

Source files
------------

// File: rtl/dfa_string_driver.sv
// Transaction wrapper for single-bit DFA recognisers: takes a string per request, resets the
// DFA, shifts the string in, then returns the sampled verdict. Define DFA_DRV_LSB_FIRST_EN for LSB-first order.
module dfa_string_driver #(
  parameter int WIDTH = 8,
  parameter int LEN_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [WIDTH-1:0] s_data,
  input  logic [LEN_W-1:0] s_len,
  output logic             dfa_rst,
  output logic             dfa_in,
  input  logic             dfa_accept,
  output logic             r_valid,
  input  logic             r_ready,
  output logic             r_accept,
  output logic [LEN_W-1:0] r_len
);

  localparam int IDLE_B   = 0;
  localparam int SHIFT_B  = 1;
  localparam int SAMPLE_B = 2;
  localparam int RESULT_B = 3;

  typedef enum logic [3:0] {
    IDLE   = 4'b0001,
    SHIFT  = 4'b0010,
    SAMPLE = 4'b0100,
    RESULT = 4'b1000
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] shreg_q;
  logic [LEN_W-1:0] cnt_q;
  logic             dfa_in_q;
  logic             r_accept_q;
  logic [LEN_W-1:0] r_len_q;

  logic [LEN_W-1:0] len_sat_s;
  logic [WIDTH-1:0] load_s;
  logic             first_bit_s;
  logic [WIDTH-1:0] load_rest_s;
  logic             next_bit_s;
  logic [WIDTH-1:0] shreg_shift_s;

  // Saturate the request length and line the string up at the shift-out end.
  always_comb begin
    len_sat_s = (s_len > LEN_W'(WIDTH)) ? LEN_W'(WIDTH) : s_len;
`ifdef DFA_DRV_LSB_FIRST_EN
    load_s        = s_data & ~({WIDTH{1'b1}} << len_sat_s);
    first_bit_s   = load_s[0];
    load_rest_s   = load_s >> 1;
    next_bit_s    = shreg_q[0];
    shreg_shift_s = shreg_q >> 1;
`else
    // Shifting left by WIDTH-len drops the unused upper bits and puts bit len-1 at the MSB.
    load_s        = s_data << (LEN_W'(WIDTH) - len_sat_s);
    first_bit_s   = load_s[WIDTH-1];
    load_rest_s   = load_s << 1;
    next_bit_s    = shreg_q[WIDTH-1];
    shreg_shift_s = shreg_q << 1;
`endif
  end

  // Control FSM with datapath; dfa_in is registered so the DFA sees a clean bit each cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      shreg_q    <= {WIDTH{1'b0}};
      cnt_q      <= {LEN_W{1'b0}};
      dfa_in_q   <= 1'b0;
      r_accept_q <= 1'b0;
      r_len_q    <= {LEN_W{1'b0}};
    end else begin
      case (state_q)
        IDLE: begin
          if (s_valid) begin
            cnt_q   <= len_sat_s;
            r_len_q <= len_sat_s;
            if (len_sat_s != {LEN_W{1'b0}}) begin
              state_q  <= SHIFT;
              shreg_q  <= load_rest_s;
              dfa_in_q <= first_bit_s;
            end else begin
              state_q  <= SAMPLE;
              shreg_q  <= {WIDTH{1'b0}};
              dfa_in_q <= 1'b0;
            end
          end else begin
            state_q  <= IDLE;
            dfa_in_q <= 1'b0;
          end
        end
        SHIFT: begin
          cnt_q <= cnt_q - LEN_W'(1);
          if (cnt_q == LEN_W'(1)) begin
            state_q  <= SAMPLE;
            dfa_in_q <= 1'b0;
          end else begin
            state_q  <= SHIFT;
            dfa_in_q <= next_bit_s;
            shreg_q  <= shreg_shift_s;
          end
        end
        SAMPLE: begin
          r_accept_q <= dfa_accept;
          dfa_in_q   <= 1'b0;
          state_q    <= RESULT;
        end
        RESULT: begin
          dfa_in_q <= 1'b0;
          if (r_ready) begin
            state_q <= IDLE;
          end else begin
            state_q <= RESULT;
          end
        end
        default: begin
          state_q  <= IDLE;
          dfa_in_q <= 1'b0;
          cnt_q    <= {LEN_W{1'b0}};
        end
      endcase
    end
  end

  assign s_ready  = state_q[IDLE_B];
  assign dfa_rst  = state_q[IDLE_B];
  assign dfa_in   = dfa_in_q;
  assign r_valid  = state_q[RESULT_B];
  assign r_accept = r_accept_q;
  assign r_len    = r_len_q;

  logic unused_s;
  assign unused_s = state_q[SHIFT_B] ^ state_q[SAMPLE_B];

endmodule

// File: tb/tb_dfa_string_driver.sv
// Directed bench for dfa_string_driver with an ends-with-0 recogniser model attached
// (start state accepting, as the attached DFA reports).
module tb_dfa_string_driver;
  localparam int WIDTH = 8;
  localparam int LEN_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             s_valid;
  logic             s_ready;
  logic [WIDTH-1:0] s_data;
  logic [LEN_W-1:0] s_len;
  logic             dfa_rst;
  logic             dfa_in;
  logic             dfa_accept;
  logic             r_valid;
  logic             r_ready;
  logic             r_accept;
  logic [LEN_W-1:0] r_len;

  int n_checks = 0;
  int n_errors = 0;
  logic tie_ready = 1'b0;

  always #5 clk = ~clk;

  dfa_string_driver #(.WIDTH(WIDTH), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst(rst),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_len(s_len),
    .dfa_rst(dfa_rst), .dfa_in(dfa_in), .dfa_accept(dfa_accept),
    .r_valid(r_valid), .r_ready(r_ready), .r_accept(r_accept), .r_len(r_len)
  );

  // Ends-with-0 acceptor: accepting after reset or after a 0 bit.
  logic dfa_q;
  always_ff @(posedge clk) begin
    if (dfa_rst) dfa_q <= 1'b1;
    else         dfa_q <= ~dfa_in;
  end
  assign dfa_accept = dfa_q;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic exp_bit(input logic [7:0] data, input int leff, input int i);
`ifdef DFA_DRV_LSB_FIRST_EN
    return data[i];
`else
    return data[leff-1-i];
`endif
  endfunction

  // Called at a negedge while the driver is idle; returns at a negedge with the driver idle again.
  task automatic run_str(input logic [7:0] data, input logic [3:0] len, input logic exp_acc,
                         input int hold);
    int leff;
    leff = (len > 4'd8) ? 8 : int'(len);
    check_eq("s_ready_idle", 32'(s_ready), 32'd1);
    check_eq("dfa_rst_idle", 32'(dfa_rst), 32'd1);
    s_valid = 1'b1; s_data = data; s_len = len;
    @(negedge clk);
    s_valid = 1'b0; s_data = ~data; s_len = 4'd0;
    for (int i = 0; i < leff; i++) begin
      check_eq("dfa_in_bit", 32'(dfa_in), 32'(exp_bit(data, leff, i)));
      check_eq("dfa_rst_shift", 32'(dfa_rst), 32'd0);
      check_eq("r_valid_shift", 32'(r_valid), 32'd0);
      check_eq("s_ready_shift", 32'(s_ready), 32'd0);
      @(negedge clk);
    end
    check_eq("dfa_in_sample", 32'(dfa_in), 32'd0);
    check_eq("dfa_rst_sample", 32'(dfa_rst), 32'd0);
    check_eq("r_valid_sample", 32'(r_valid), 32'd0);
    @(negedge clk);
    check_eq("r_valid_rise", 32'(r_valid), 32'd1);
    check_eq("r_accept", 32'(r_accept), 32'(exp_acc));
    check_eq("r_len", 32'(r_len), 32'(leff));
    check_eq("s_ready_result", 32'(s_ready), 32'd0);
    check_eq("dfa_in_result", 32'(dfa_in), 32'd0);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check_eq("hold_r_valid", 32'(r_valid), 32'd1);
      check_eq("hold_r_accept", 32'(r_accept), 32'(exp_acc));
      check_eq("hold_r_len", 32'(r_len), 32'(leff));
      check_eq("hold_s_ready", 32'(s_ready), 32'd0);
    end
    r_ready = 1'b1;
    @(negedge clk);
    check_eq("s_ready_after_result", 32'(s_ready), 32'd1);
    check_eq("r_valid_after_result", 32'(r_valid), 32'd0);
    if (!tie_ready) r_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; s_valid = 1'b0; s_data = 8'h00; s_len = 4'd0; r_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_eq("rst_s_ready", 32'(s_ready), 32'd1);
    check_eq("rst_dfa_rst", 32'(dfa_rst), 32'd1);
    check_eq("rst_dfa_in", 32'(dfa_in), 32'd0);
    check_eq("rst_r_valid", 32'(r_valid), 32'd0);
    check_eq("rst_r_accept", 32'(r_accept), 32'd0);
    check_eq("rst_r_len", 32'(r_len), 32'd0);
    rst = 1'b0;
    @(negedge clk);

`ifdef DFA_DRV_LSB_FIRST_EN
    run_str(8'b0000_0110, 4'd3, 1'b0, 0);
`else
    run_str(8'b0000_0110, 4'd3, 1'b1, 0);
`endif
    run_str(8'hA5, 4'd0, 1'b1, 0);
    run_str(8'hFF, 4'd9, 1'b0, 0);
    run_str(8'b1111_0010, 4'd4, 1'b1, 0);
`ifdef DFA_DRV_LSB_FIRST_EN
    run_str(8'b1111_1110, 4'd8, 1'b0, 0);
    run_str(8'b0101_0100, 4'd7, 1'b0, 20);
`else
    run_str(8'b1111_1110, 4'd8, 1'b1, 0);
    run_str(8'b0101_0100, 4'd7, 1'b1, 20);
`endif
    run_str(8'b0000_0001, 4'd1, 1'b0, 0);

    // Reset during the second SHIFT cycle of an 8-bit string.
    s_valid = 1'b1; s_data = 8'h3C; s_len = 4'd8;
    @(negedge clk);
    s_valid = 1'b0;
    check_eq("abort_shift1_rst", 32'(dfa_rst), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_eq("abort_s_ready", 32'(s_ready), 32'd1);
    check_eq("abort_dfa_rst", 32'(dfa_rst), 32'd1);
    check_eq("abort_r_valid", 32'(r_valid), 32'd0);
    check_eq("abort_dfa_in", 32'(dfa_in), 32'd0);
`ifdef DFA_DRV_LSB_FIRST_EN
    run_str(8'h02, 4'd2, 1'b0, 0);
`else
    run_str(8'h02, 4'd2, 1'b1, 0);
`endif

    // Back-to-back with r_ready tied high.
    tie_ready = 1'b1;
    r_ready = 1'b1;
    run_str(8'h0F, 4'd4, 1'b0, 0);
    run_str(8'h00, 4'd5, 1'b1, 0);
    run_str(8'h81, 4'd8, 1'b0, 0);
`ifdef DFA_DRV_LSB_FIRST_EN
    run_str(8'h06, 4'd3, 1'b0, 0);
`else
    run_str(8'h06, 4'd3, 1'b1, 0);
`endif
    r_ready = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
